// File: rtl/spi_flash_pkg.sv
// Shared opcodes, state encoding and address framing for the SPI flash responder.
package spi_flash_pkg;

   localparam logic [7:0]  CMD_READ   = 8'h03;
   localparam logic [7:0]  CMD_RDID   = 8'h9F;
   localparam logic [7:0]  CMD_RDSR   = 8'h05;
   localparam int unsigned ADDR_BYTES = 3;
   localparam int unsigned ADDR_BITS  = ADDR_BYTES * 8;

   typedef enum logic [2:0] {
      IDLE,
      CMD,
      ADDR,
      DATA,
      ID,
      STAT,
      IGNORE
   } spi_resp_state_e;

endpackage

// File: rtl/spi_resp_mem.sv
// 1R1W synchronous byte RAM holding the flash image; read-first on a same-cycle collision.
module spi_resp_mem #(
   parameter int unsigned AW = 12
) (
   input  logic          clk_i,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [7:0]    wdata_i,
   input  logic          re_i,
   input  logic [AW-1:0] raddr_i,
   output logic [7:0]    rdata_o
);

   logic [7:0] r_mem [0:(1<<AW)-1];
   logic [7:0] r_rdata;

   always_ff @(posedge clk_i) begin
      if (we_i) r_mem[waddr_i] <= wdata_i;
      if (re_i) r_rdata <= r_mem[raddr_i];
   end

   assign rdata_o = r_rdata;

endmodule

// File: rtl/spi_flash_resp.sv
// SPI mode-0 flash responder (READ/RDID/RDSR) serving a small on-chip image,
// with SPI pins oversampled in the clk_i domain.
module spi_flash_resp
   import spi_flash_pkg::*;
#(
   parameter int unsigned MEM_AW    = 12,
   parameter logic [23:0] JEDEC_ID  = 24'h20BA18,
   parameter int unsigned TXN_CNT_W = 16
) (
   input  logic                 clk_i,
   input  logic                 rst_n_i,
   input  logic                 spi_sclk_i,
   input  logic                 spi_cs_n_i,
   input  logic                 spi_mosi_i,
   output logic                 spi_miso_o,
   output logic                 spi_miso_oe_o,
   input  logic                 ld_we_i,
   input  logic [MEM_AW-1:0]    ld_addr_i,
   input  logic [7:0]           ld_data_i,
   output logic                 busy_o,
   output logic [TXN_CNT_W-1:0] txn_cnt_o
);

   logic [1:0]           r_sclk_sync, r_cs_sync, r_mosi_sync;
   logic                 r_sclk_d, r_cs_d;
   logic                 w_sclk_rise, w_sclk_fall, w_cs_rise, w_cs_fall, w_mosi;

   spi_resp_state_e      r_state;
   logic [4:0]           r_bit_cnt;
   logic [2:0]           r_tx_cnt;
   logic [6:0]           r_shift_in;
   logic [7:0]           w_shift_next;
   logic [MEM_AW-1:0]    r_addr;
   logic [7:0]           r_tx;
   logic [1:0]           r_id_idx;
   logic [7:0]           w_id_next;
   logic                 r_byte_done;
   logic                 r_rd_en, r_rd_wait;
   logic [7:0]           w_rd_data;
   logic                 r_miso, r_oe, r_busy;
   logic [TXN_CNT_W-1:0] r_txn_cnt;

   // cs_n resets to the low level so a frame already in flight at reset
   // produces no falling edge; the block re-arms on the next real fall.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         r_sclk_sync <= '0;
         r_cs_sync   <= '0;
         r_mosi_sync <= '0;
         r_sclk_d    <= 1'b0;
         r_cs_d      <= 1'b0;
      end else begin
         r_sclk_sync <= {r_sclk_sync[0], spi_sclk_i};
         r_cs_sync   <= {r_cs_sync[0], spi_cs_n_i};
         r_mosi_sync <= {r_mosi_sync[0], spi_mosi_i};
         r_sclk_d    <= r_sclk_sync[1];
         r_cs_d      <= r_cs_sync[1];
      end
   end

   assign w_sclk_rise  =  r_sclk_sync[1] & ~r_sclk_d;
   assign w_sclk_fall  = ~r_sclk_sync[1] &  r_sclk_d;
   assign w_cs_rise    =  r_cs_sync[1]   & ~r_cs_d;
   assign w_cs_fall    = ~r_cs_sync[1]   &  r_cs_d;
   assign w_mosi       =  r_mosi_sync[1];
   assign w_shift_next = {r_shift_in, w_mosi};

   always_comb begin
      w_id_next = '0;
      case (r_id_idx)
         2'd1:    w_id_next = JEDEC_ID[15:8];
         2'd2:    w_id_next = JEDEC_ID[7:0];
         default: w_id_next = '0;
      endcase
   end

   spi_resp_mem #(.AW(MEM_AW)) u_mem (
      .clk_i   (clk_i),
      .we_i    (ld_we_i),
      .waddr_i (ld_addr_i),
      .wdata_i (ld_data_i),
      .re_i    (r_rd_en),
      .raddr_i (r_addr),
      .rdata_o (w_rd_data)
   );

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         r_state     <= IDLE;
         r_bit_cnt   <= '0;
         r_tx_cnt    <= '0;
         r_shift_in  <= '0;
         r_addr      <= '0;
         r_tx        <= '0;
         r_id_idx    <= '0;
         r_byte_done <= 1'b0;
         r_rd_en     <= 1'b0;
         r_rd_wait   <= 1'b0;
         r_miso      <= 1'b0;
         r_oe        <= 1'b0;
         r_busy      <= 1'b0;
         r_txn_cnt   <= '0;
      end else begin
         r_rd_en   <= 1'b0;
         r_rd_wait <= r_rd_en;
         if (r_rd_wait) r_tx <= w_rd_data;

         if (w_cs_rise) begin
            if ((r_state == DATA || r_state == ID || r_state == STAT) && r_byte_done)
               r_txn_cnt <= r_txn_cnt + 1'b1;
            r_state <= IDLE;
            r_oe    <= 1'b0;
            r_miso  <= 1'b0;
            r_busy  <= 1'b0;
         end else begin
            unique case (r_state)
               IDLE: begin
                  if (w_cs_fall) begin
                     r_state     <= CMD;
                     r_bit_cnt   <= '0;
                     r_tx_cnt    <= '0;
                     r_byte_done <= 1'b0;
                     r_busy      <= 1'b1;
                  end
               end
               CMD: begin
                  if (w_sclk_rise) begin
                     r_shift_in <= w_shift_next[6:0];
                     r_bit_cnt  <= r_bit_cnt + 1'b1;
                     if (r_bit_cnt == 5'd7) begin
                        r_bit_cnt <= '0;
                        case (w_shift_next)
                           CMD_READ: r_state <= ADDR;
                           CMD_RDID: begin
                              r_state  <= ID;
                              r_oe     <= 1'b1;
                              r_tx     <= JEDEC_ID[23:16];
                              r_id_idx <= 2'd1;
                           end
                           CMD_RDSR: begin
                              r_state <= STAT;
                              r_oe    <= 1'b1;
                              r_tx    <= '0;
                           end
                           default: r_state <= IGNORE;
                        endcase
                     end
                  end
               end
               ADDR: begin
                  // Upper address bits shift out of the top and are dropped.
                  if (w_sclk_rise) begin
                     r_addr    <= {r_addr[MEM_AW-2:0], w_mosi};
                     r_bit_cnt <= r_bit_cnt + 1'b1;
                     if (r_bit_cnt == 5'(ADDR_BITS - 1)) begin
                        r_bit_cnt <= '0;
                        r_state   <= DATA;
                        r_oe      <= 1'b1;
                        r_rd_en   <= 1'b1;
                     end
                  end
               end
               DATA, ID, STAT: begin
                  // Rises count bits the master has taken; a full byte makes the frame countable.
                  if (w_sclk_rise) begin
                     r_bit_cnt <= r_bit_cnt + 1'b1;
                     if (r_bit_cnt[2:0] == 3'd7) r_byte_done <= 1'b1;
                  end
                  if (w_sclk_fall) begin
                     r_miso   <= r_tx[7];
                     r_tx_cnt <= r_tx_cnt + 1'b1;
                     if (r_tx_cnt == 3'd7) begin
                        case (r_state)
                           DATA: begin
                              r_addr  <= r_addr + 1'b1;
                              r_rd_en <= 1'b1;
                           end
                           ID: begin
                              r_tx <= w_id_next;
                              if (r_id_idx != 2'd3) r_id_idx <= r_id_idx + 1'b1;
                           end
                           default: r_tx <= '0;
                        endcase
                     end else begin
                        r_tx <= {r_tx[6:0], 1'b0};
                     end
                  end
               end
               IGNORE: ;
               default: r_state <= IDLE;
            endcase
         end
      end
   end

   assign spi_miso_o    = r_miso;
   assign spi_miso_oe_o = r_oe;
   assign busy_o        = r_busy;
   assign txn_cnt_o     = r_txn_cnt;

endmodule

// File: tb/tb_spi_flash_resp.sv
// Directed bench for spi_flash_resp: acts as a mode-0 SPI master at clk_i/8
// and checks returned bytes, output enable, busy and the transaction counter.
module tb_spi_flash_resp;

   logic        clk = 1'b0;
   logic        rst_n, sclk, cs_n, mosi, miso, oe, ld_we, busy;
   logic [11:0] ld_addr;
   logic [7:0]  ld_data;
   logic [15:0] txn;
   logic [7:0]  rx;
   logic        oe_seen;
   int          n_checks = 0;
   int          n_fail   = 0;

   always #5 clk = ~clk;

   spi_flash_resp #(
      .MEM_AW    (12),
      .JEDEC_ID  (24'h20BA18),
      .TXN_CNT_W (16)
   ) dut (
      .clk_i         (clk),
      .rst_n_i       (rst_n),
      .spi_sclk_i    (sclk),
      .spi_cs_n_i    (cs_n),
      .spi_mosi_i    (mosi),
      .spi_miso_o    (miso),
      .spi_miso_oe_o (oe),
      .ld_we_i       (ld_we),
      .ld_addr_i     (ld_addr),
      .ld_data_i     (ld_data),
      .busy_o        (busy),
      .txn_cnt_o     (txn)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Master samples miso on each rise; partial transfers leave bits in the LSBs.
   task automatic xfer(input logic [7:0] tx, input int unsigned nbits, output logic [7:0] r);
      r = '0;
      for (int unsigned i = 0; i < nbits; i++) begin
         mosi = tx[7-i];
         #40;
         sclk = 1'b1;
         r = {r[6:0], miso};
         oe_seen = oe_seen | oe;
         #40;
         sclk = 1'b0;
      end
   endtask

   task automatic load(input logic [11:0] a, input logic [7:0] d);
      ld_addr = a;
      ld_data = d;
      ld_we   = 1'b1;
      #10;
      ld_we   = 1'b0;
      #10;
   endtask

   task automatic read_hdr(input logic [23:0] a);
      cs_n = 1'b0;
      #40;
      xfer(8'h03, 8, rx);
      xfer(a[23:16], 8, rx);
      xfer(a[15:8], 8, rx);
      xfer(a[7:0], 8, rx);
   endtask

   task automatic end_frame();
      #40;
      cs_n = 1'b1;
      #80;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n = 1'b0; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0;
      ld_we = 1'b0; ld_addr = '0; ld_data = '0; oe_seen = 1'b0;
      @(posedge clk);
      #2;
      #30;
      check("rst_miso", miso, 0);
      check("rst_oe",   oe,   0);
      check("rst_busy", busy, 0);
      check("rst_txn",  txn,  0);
      rst_n = 1'b1;
      #20;

      load(12'h000, 8'hA5);
      load(12'h001, 8'h3C);
      load(12'h002, 8'hF0);

      // READ 0x000000, 3 bytes, then oe release timing
      read_hdr(24'h000000);
      xfer(8'h00, 8, rx); check("rd0_b0", rx, 8'hA5);
      xfer(8'h00, 8, rx); check("rd0_b1", rx, 8'h3C);
      xfer(8'h00, 8, rx); check("rd0_b2", rx, 8'hF0);
      check("rd0_busy", busy, 1);
      #40;
      cs_n = 1'b1;
      #23;
      check("rd0_oe_held", oe, 1);
      #10;
      check("rd0_oe_drop", oe, 0);
      check("rd0_busy_drop", busy, 0);
      check("rd0_txn", txn, 1);
      #7;

      // address wrap
      load(12'hFFF, 8'h11);
      load(12'h000, 8'h22);
      read_hdr(24'h000FFF);
      xfer(8'h00, 8, rx); check("wrap_b0", rx, 8'h11);
      xfer(8'h00, 8, rx); check("wrap_b1", rx, 8'h22);
      end_frame();
      check("wrap_txn", txn, 2);
      load(12'h000, 8'hA5);

      // RDID then RDSR
      cs_n = 1'b0; #40;
      xfer(8'h9F, 8, rx);
      xfer(8'h00, 8, rx); check("id_b0", rx, 8'h20);
      xfer(8'h00, 8, rx); check("id_b1", rx, 8'hBA);
      xfer(8'h00, 8, rx); check("id_b2", rx, 8'h18);
      xfer(8'h00, 8, rx); check("id_b3", rx, 8'h00);
      end_frame();
      check("id_txn", txn, 3);
      cs_n = 1'b0; #40;
      xfer(8'h05, 8, rx);
      xfer(8'h00, 8, rx); check("sr_b0", rx, 8'h00);
      check("sr_oe", oe, 1);
      xfer(8'h00, 8, rx); check("sr_b1", rx, 8'h00);
      end_frame();
      check("sr_txn", txn, 4);

      // unknown opcode
      cs_n = 1'b0; #40;
      oe_seen = 1'b0;
      xfer(8'h0B, 8, rx);
      xfer(8'h00, 8, rx);
      xfer(8'h00, 8, rx);
      check("ign_oe_seen", oe_seen, 0);
      check("ign_busy", busy, 1);
      end_frame();
      check("ign_busy_drop", busy, 0);
      check("ign_txn", txn, 4);

      // abort after 12 address bits, then READ 0x000001
      cs_n = 1'b0; #40;
      xfer(8'h03, 8, rx);
      xfer(8'h00, 8, rx);
      xfer(8'h00, 4, rx);
      end_frame();
      check("abort_busy", busy, 0);
      check("abort_oe", oe, 0);
      check("abort_txn", txn, 4);
      read_hdr(24'h000001);
      xfer(8'h00, 8, rx); check("rd1_b0", rx, 8'h3C);
      end_frame();
      check("rd1_txn", txn, 5);

      // reset mid-DATA with cs_n held low
      read_hdr(24'h000000);
      xfer(8'h00, 4, rx); check("pre_rst_nibble", rx, 8'h0A);
      rst_n = 1'b0;
      #10;
      check("midrst_miso", miso, 0);
      check("midrst_oe",   oe,   0);
      check("midrst_busy", busy, 0);
      check("midrst_txn",  txn,  0);
      #20;
      rst_n = 1'b1;
      oe_seen = 1'b0;
      xfer(8'h00, 4, rx);
      check("postrst_oe_seen", oe_seen, 0);
      check("postrst_busy", busy, 0);
      end_frame();
      check("postrst_txn", txn, 0);
      read_hdr(24'h000000);
      xfer(8'h00, 8, rx); check("rearm_b0", rx, 8'hA5);
      end_frame();
      check("rearm_txn", txn, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
